stream_mux_rr: RTL and testbench

//  Parametrised, registered N-channel stream multiplexer; successor to the combinational 4:1 enable mux.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/stream_mux_rr.sv | 128 ++++++++++++
 tb/tb_stream_mux_rr.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types for the registered round-robin stream mux
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mux_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from last_gnt+1
// req: per-channel request; last_gnt: most recent winner; gnt_idx/gnt_vld: winner and whether any request exists
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last_gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int idx;

    // Walk candidates farthest-first so the nearest requester after last_gnt
    // overwrites earlier hits and ends up as the winner.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = (int'(last_gnt) + k) % N_CH;
            if (req[SEL_W'(idx)]) begin
                gnt_idx = SEL_W'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - packet-aware N-channel stream mux with fixed or round-robin select and one output register
// clk/rst: rising-edge clock, synchronous active-high reset
// en/mode/sel: accept enable, FIXED(0)/RR(1) select mode, fixed-mode channel select
// in_valid/in_data/in_last/in_ready: N_CH input streams, channel i at in_data[i*WIDTH +: WIDTH]
// out_valid/out_data/out_last/out_ch/out_ready: registered output stream with source channel tag
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_last,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    import stream_mux_pkg::*;

    mux_state_e        state_q, state_d;
    logic [SEL_W-1:0]  lock_ch_q;
    logic [SEL_W-1:0]  rr_last_q;
    logic [SEL_W-1:0]  gnt;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_vld;
    logic              gnt_ok;
    logic              can_acc;
    logic              accept;
    logic [WIDTH-1:0]  gnt_data;
    logic              gnt_last;
    // Valid vector padded to the full select range so out-of-range selects
    // simply read a zero instead of needing a bounds compare.
    logic [(2**SEL_W)-1:0] valid_ext;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req      (in_valid),
        .last_gnt (rr_last_q),
        .gnt_idx  (arb_idx),
        .gnt_vld  (arb_vld)
    );

    always_comb begin
        valid_ext             = '0;
        valid_ext[N_CH-1:0]   = in_valid;
        gnt                   = sel;
        gnt_ok                = 1'b0;
        if (state_q == LOCKED) begin
            gnt    = lock_ch_q;
            gnt_ok = valid_ext[lock_ch_q];
        end else if (mux_mode_e'(mode) == MODE_RR) begin
            gnt    = arb_idx;
            gnt_ok = arb_vld;
        end else begin
            gnt    = sel;
            gnt_ok = valid_ext[sel];
        end
        // The output slot is free when empty or being drained this same cycle.
        can_acc = en && (!out_valid || out_ready);
        accept  = can_acc && gnt_ok;
    end

    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt == SEL_W'(i)) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                gnt_last    = in_last[i];
                in_ready[i] = accept;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !gnt_last) state_d = LOCKED;
            LOCKED:  if (accept && gnt_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            rr_last_q <= SEL_W'(N_CH - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            state_q <= state_d;
            if (accept && state_q == IDLE) begin
                lock_ch_q <= gnt;
            end
            // Updated on packet end in both modes so RR resumes past the
            // channel that most recently finished, even after FIXED traffic.
            if (accept && gnt_last) begin
                rr_last_q <= gnt;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_last  <= gnt_last;
                out_ch    <= gnt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized scoreboard bench for stream_mux_rr
module tb_stream_mux_rr;

    localparam int WIDTH = 4;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
        logic [SEL_W-1:0] ch;
    } beat_t;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_ready;

    int checks = 0;
    int errors = 0;

    // Source beats per channel, {last, data}; offer = source presents its head beat.
    logic [WIDTH:0]  src_q [N_CH][$];
    logic [N_CH-1:0] offer;
    beat_t           exp_q [$];

    // Reference state: locked channel, last finished channel, output slot occupied.
    bit m_locked;
    int m_lock;
    int m_rr;
    bit m_held;

    stream_mux_rr #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        int len;
        for (int i = 0; i < N_CH; i++) begin
            if (src_q[i].size() == 0) begin
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++)
                    src_q[i].push_back({(j == len - 1), 4'($urandom)});
            end
        end
    endtask

    // Drive the sources, then predict this edge's outcome from the stream rules.
    task automatic cycle();
        logic [N_CH-1:0] vld;
        logic [N_CH-1:0] exp_rdy;
        logic [WIDTH:0]  b;
        bit              ca;
        bit              acc;
        int              g;
        for (int i = 0; i < N_CH; i++) begin
            vld[i] = offer[i] && (src_q[i].size() > 0) && !rst;
            if (src_q[i].size() > 0) begin
                in_data[i*WIDTH +: WIDTH] = src_q[i][0][WIDTH-1:0];
                in_last[i]                = src_q[i][0][WIDTH];
            end else begin
                in_data[i*WIDTH +: WIDTH] = 4'($urandom);
                in_last[i]                = 1'($urandom);
            end
        end
        in_valid = vld;
        #1;
        if (rst) begin
            chk("in_ready_in_reset", in_ready, 0);
            exp_q.delete();
            m_locked = 0;
            m_rr     = N_CH - 1;
            m_held   = 0;
            return;
        end
        chk("out_valid", out_valid, m_held);
        ca = en && (!m_held || out_ready);
        g  = -1;
        if (m_locked) begin
            g = m_lock;
        end else if (mode) begin
            for (int k = 1; k <= N_CH; k++) begin
                if (vld[(m_rr + k) % N_CH]) begin
                    g = (m_rr + k) % N_CH;
                    break;
                end
            end
        end else begin
            g = int'(sel);
        end
        acc     = ca && (g >= 0) && (g < N_CH) && vld[g];
        exp_rdy = acc ? N_CH'(1 << g) : '0;
        chk("in_ready", in_ready, exp_rdy);
        if (acc) begin
            b = src_q[g].pop_front();
            exp_q.push_back('{data: b[WIDTH-1:0], last: b[WIDTH], ch: SEL_W'(g)});
            offer[g] = 1'b0;
            if (b[WIDTH]) begin
                m_locked = 0;
                m_rr     = g;
            end else begin
                m_locked = 1;
                m_lock   = g;
            end
        end
        m_held = acc || (m_held && !out_ready);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        offer = '0;
        cycle();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_ch", out_ch, 0);
        cycle();
    endtask

    // Monitor: every presented beat must match the oldest predicted beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q[0];
                        chk("out_data", out_data, e.data);
                        chk("out_last", out_last, e.last);
                        chk("out_ch", out_ch, e.ch);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("idle_out_data", out_data, 0);
                    chk("idle_out_last", out_last, 0);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
        offer     = '0;
        m_locked  = 0;
        m_lock    = 0;
        m_rr      = N_CH - 1;
        m_held    = 0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_out_ch", out_ch, 0);
        chk("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        en  = 1'b1;
        out_ready = 1'b1;

        // FIXED select of channel 2 carrying a single-beat packet of 4'hA.
        @(negedge clk);
        mode = 1'b0;
        sel  = 2'd2;
        src_q[2].push_back({1'b1, 4'hA});
        offer = 4'b0100;
        cycle();
        chk("fixed_in_ready", in_ready, 4'b0100);

        // 0: saturated RR; 1: random mix; 2: heavy back-pressure and en gaps.
        for (int p = 0; p < 3; p++) begin
            for (int n = 0; n < 400; n++) begin
                @(negedge clk);
                refill();
                if (p == 0) begin
                    mode      = 1'b1;
                    en        = 1'b1;
                    out_ready = 1'b1;
                    offer     = '1;
                end else begin
                    for (int i = 0; i < N_CH; i++)
                        if (!offer[i]) offer[i] = ($urandom % 3) != 0;
                    if ($urandom % 16 == 0) mode = ~mode;
                    if ($urandom % 8 == 0)  sel = SEL_W'($urandom);
                    en        = (p == 2) ? (($urandom % 2) != 0) : (($urandom % 8) != 0);
                    out_ready = (p == 2) ? (($urandom % 3) == 0) : (($urandom % 4) != 0);
                end
                cycle();
            end
        end

        // Reset in the middle of a channel-3 packet, then RR must start at ch0.
        en = 1'b1;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < N_CH; i++) src_q[i].delete();
        src_q[3].push_back({1'b0, 4'h1});
        src_q[3].push_back({1'b0, 4'h2});
        src_q[3].push_back({1'b1, 4'h3});
        mode = 1'b0;
        sel  = 2'd3;
        repeat (2) begin
            @(negedge clk);
            offer = 4'b1000;
            cycle();
        end
        do_reset();
        refill();
        @(negedge clk);
        mode  = 1'b1;
        offer = '1;
        cycle();
        chk("post_reset_rr_first", in_ready, 4'b0001);

        // Drain whatever is still held.
        offer = '0;
        repeat (6) begin
            @(negedge clk);
            en = 1'b1;
            out_ready = 1'b1;
            cycle();
        end
        #3;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
